// File: rtl/entry_input_conditioner_if.sv
// Board-side bundle for the entry input conditioner: raw buttons/switches in, conditioned strobes out.
// Ports: btn_enter_raw, btn_lock_raw, sw_raw (raw inputs); x_out, enter_pulse, lock_pulse,
//        enter_level, entry_count (conditioned outputs). master = stimulus side, slave = conditioner.
interface entry_input_conditioner_if #(
  parameter int COUNT_W = 8
);
  logic               btn_enter_raw;
  logic               btn_lock_raw;
  logic [3:0]         sw_raw;
  logic [3:0]         x_out;
  logic               enter_pulse;
  logic               lock_pulse;
  logic               enter_level;
  logic [COUNT_W-1:0] entry_count;

  modport master (
    output btn_enter_raw, btn_lock_raw, sw_raw,
    input  x_out, enter_pulse, lock_pulse, enter_level, entry_count
  );

  modport slave (
    input  btn_enter_raw, btn_lock_raw, sw_raw,
    output x_out, enter_pulse, lock_pulse, enter_level, entry_count
  );
endinterface

// File: rtl/entry_input_conditioner.sv
// Purpose: synchronize + debounce enter/lock buttons, emit one-cycle press strobes, capture digit on enter.
// Latency: raw press clean before edge 1 -> strobe high in the cycle after edge DEBOUNCE_CYCLES+3.
// Backpressure: none; strobes are fire-and-forget, the downstream lock FSM samples them every cycle.
// Ports: clk, reset (sync, active-low); io.slave carries the raw inputs and the conditioned outputs
//        (x_out digit, enter_pulse/lock_pulse strobes, enter_level debounced level, entry_count).
module entry_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_W         = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  entry_input_conditioner_if.slave   io
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter value seen on the edge where the new level gets accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 = enter button, bit 1 = lock button throughout.
  logic [1:0]            btn_s1_q, btn_s1_d;
  logic [1:0]            btn_s_q, btn_s_d;
  logic [3:0]            sw_s1_q, sw_s1_d;
  logic [3:0]            sw_s_q, sw_s_d;
  logic [1:0]            stable_q, stable_d;
  logic [1:0]            stable_prev_q, stable_prev_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  enter_pulse_q, enter_pulse_d;
  logic                  lock_pulse_q, lock_pulse_d;
  logic [3:0]            x_out_q, x_out_d;
  logic [COUNT_W-1:0]    entry_count_q, entry_count_d;
  logic [1:0]            rise;

  always_comb begin
    btn_s1_d = {io.btn_lock_raw, io.btn_enter_raw};
    btn_s_d  = btn_s1_q;
    sw_s1_d  = io.sw_raw;
    sw_s_d   = sw_s1_q;

    // Debounce: any return to the stable level restarts the count.
    stable_d = stable_q;
    cnt_d    = '0;
    for (int b = 0; b < 2; b++) begin
      if (btn_s_q[b] != stable_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          stable_d[b] = btn_s_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end

    stable_prev_d = stable_q;
    rise          = stable_q & ~stable_prev_q;

    // Lock wins a tie; the coincident enter press is dropped, not deferred.
    lock_pulse_d  = rise[1];
    enter_pulse_d = rise[0] & ~rise[1];

    x_out_d       = enter_pulse_d ? sw_s_q : x_out_q;
    entry_count_d = entry_count_q + COUNT_W'(enter_pulse_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_s1_q      <= '0;
      btn_s_q       <= '0;
      sw_s1_q       <= '0;
      sw_s_q        <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      cnt_q         <= '0;
      enter_pulse_q <= 1'b0;
      lock_pulse_q  <= 1'b0;
      x_out_q       <= '0;
      entry_count_q <= '0;
    end else begin
      btn_s1_q      <= btn_s1_d;
      btn_s_q       <= btn_s_d;
      sw_s1_q       <= sw_s1_d;
      sw_s_q        <= sw_s_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      cnt_q         <= cnt_d;
      enter_pulse_q <= enter_pulse_d;
      lock_pulse_q  <= lock_pulse_d;
      x_out_q       <= x_out_d;
      entry_count_q <= entry_count_d;
    end
  end

  assign io.x_out       = x_out_q;
  assign io.enter_pulse = enter_pulse_q;
  assign io.lock_pulse  = lock_pulse_q;
  assign io.enter_level = stable_q[0];
  assign io.entry_count = entry_count_q;

endmodule

// File: tb/tb_entry_input_conditioner.sv
module tb_entry_input_conditioner;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enter_raw = 1'b0;
  logic       lock_raw = 1'b0;
  logic [3:0] sw = 4'h0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  entry_input_conditioner_if #(.COUNT_W(8)) io8 ();
  entry_input_conditioner_if #(.COUNT_W(2)) io2 ();

  assign io8.btn_enter_raw = enter_raw;
  assign io8.btn_lock_raw  = lock_raw;
  assign io8.sw_raw        = sw;
  assign io2.btn_enter_raw = enter_raw;
  assign io2.btn_lock_raw  = lock_raw;
  assign io2.sw_raw        = sw;

  entry_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .io(io8)
  );
  entry_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .COUNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .io(io2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A press is accepted once the (2-cycle delayed) button sample has differed from the
  // accepted level for DEB consecutive edges; the strobe appears one edge later.
  typedef struct { bit is_lock; int cyc; } ev_t;
  ev_t exp_q[$];

  bit         e_s1, e_s, l_s1, l_s;
  logic [3:0] sw_s1, sw_s;
  bit   [1:0] m_stable;
  int         run [2];
  bit         pend_e, pend_l;
  logic [3:0] m_x = 4'h0;
  int         m_cnt = 0;

  always @(posedge clk) begin
    bit [1:0] syn;
    bit [1:0] acc;
    cyc++;
    if (!reset) begin
      e_s1 = 0; e_s = 0; l_s1 = 0; l_s = 0;
      sw_s1 = 4'h0; sw_s = 4'h0;
      m_stable = 2'b00; run[0] = 0; run[1] = 0;
      pend_e = 0; pend_l = 0;
      m_x = 4'h0; m_cnt = 0;
    end else begin
      if (pend_l) exp_q.push_back('{1'b1, cyc});
      if (pend_e) begin
        m_x = sw_s;
        m_cnt++;
        exp_q.push_back('{1'b0, cyc});
      end
      acc = 2'b00;
      syn = {l_s, e_s};
      for (int b = 0; b < 2; b++) begin
        if (syn[b] != m_stable[b]) begin
          run[b]++;
          if (run[b] == DEB) begin
            m_stable[b] = syn[b];
            run[b] = 0;
            acc[b] = syn[b];
          end
        end else begin
          run[b] = 0;
        end
      end
      pend_l = acc[1];
      pend_e = acc[0] & ~acc[1];
      e_s = e_s1; e_s1 = enter_raw;
      l_s = l_s1; l_s1 = lock_raw;
      sw_s = sw_s1; sw_s1 = sw;
    end
  end

  // ---------------- monitor ----------------
  int         n_enter_seen = 0;
  int         n_lock_seen = 0;
  int         last_enter_cyc = 0;
  logic [3:0] last_enter_x = 4'h0;

  initial begin
    ev_t ev;
    bit  exp_e, exp_l;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_e = 0;
      exp_l = 0;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ev = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse: lock=%0d due at edge %0d not seen (now %0d)", ev.is_lock, ev.cyc, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ev = exp_q.pop_front();
        exp_e = !ev.is_lock;
        exp_l = ev.is_lock;
      end
      chk("enter_pulse", 32'(io8.enter_pulse), 32'(exp_e));
      chk("lock_pulse", 32'(io8.lock_pulse), 32'(exp_l));
      chk("enter_pulse_w", 32'(io2.enter_pulse), 32'(exp_e));
      chk("lock_pulse_w", 32'(io2.lock_pulse), 32'(exp_l));
      chk("enter_level", 32'(io8.enter_level), 32'(m_stable[0]));
      chk("x_out", 32'(io8.x_out), 32'(m_x));
      chk("x_out_w", 32'(io2.x_out), 32'(m_x));
      chk("entry_count", 32'(io8.entry_count), 32'(m_cnt % 256));
      chk("entry_count_w", 32'(io2.entry_count), 32'(m_cnt % 4));
      if (io8.enter_pulse === 1'b1) begin
        n_enter_seen++;
        last_enter_cyc = cyc;
        last_enter_x = io8.x_out;
      end
      if (io8.lock_pulse === 1'b1) n_lock_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic press(input logic [3:0] d, input int hold);
    sw = d;
    tick(3);
    enter_raw = 1'b1;
    tick(hold);
    enter_raw = 1'b0;
    tick(8);
  endtask

  initial begin
    int n0, l0, raise_cyc, rel_cyc;
    logic [3:0] digits [4];
    digits[0] = 4'h2; digits[1] = 4'h3; digits[2] = 4'h4; digits[3] = 4'h6;

    reset = 1'b0;
    tick(3);
    chk("reset_x", 32'(io8.x_out), 0);
    chk("reset_count", 32'(io8.entry_count), 0);
    chk("reset_level", 32'(io8.enter_level), 0);
    chk("reset_pulse", 32'(io8.enter_pulse | io8.lock_pulse), 0);
    reset = 1'b1;
    tick(1);

    // Clean press, held 20 cycles
    sw = 4'h2;
    tick(3);
    n0 = n_enter_seen;
    raise_cyc = cyc;
    enter_raw = 1'b1;
    tick(20);
    enter_raw = 1'b0;
    tick(10);
    chk("clean_pulses", 32'(n_enter_seen - n0), 1);
    chk("clean_latency", 32'(last_enter_cyc - raise_cyc), DEB + 3);
    chk("clean_x", 32'(last_enter_x), 2);
    chk("clean_count", 32'(io8.entry_count), 1);

    // Bounce rejection
    do_reset();
    n0 = n_enter_seen;
    for (int t = 0; t < 30; ) begin
      int h, l;
      h = $urandom_range(1, 3);
      l = $urandom_range(1, 3);
      enter_raw = 1'b1; tick(h);
      enter_raw = 1'b0; tick(l);
      t += h + l;
    end
    tick(10);
    chk("bounce_pulses", 32'(n_enter_seen - n0), 0);
    chk("bounce_count", 32'(io8.entry_count), 0);
    chk("bounce_level", 32'(io8.enter_level), 0);

    // Digit sequence 2,3,4,6 with switch changes between presses
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(digits[i], 10);
      chk("seq_x_at_pulse", 32'(last_enter_x), 32'(digits[i]));
      sw = digits[i] ^ 4'hF;
      tick(6);
      chk("seq_x_hold", 32'(io8.x_out), 32'(digits[i]));
    end
    chk("seq_count", 32'(io8.entry_count), 4);

    // Simultaneous enter + lock: lock wins
    do_reset();
    press(4'h5, 10);
    n0 = n_enter_seen;
    l0 = n_lock_seen;
    sw = 4'h9;
    tick(3);
    enter_raw = 1'b1;
    lock_raw = 1'b1;
    tick(15);
    enter_raw = 1'b0;
    lock_raw = 1'b0;
    tick(10);
    chk("simul_lock", 32'(n_lock_seen - l0), 1);
    chk("simul_enter", 32'(n_enter_seen - n0), 0);
    chk("simul_x", 32'(io8.x_out), 5);
    chk("simul_count", 32'(io8.entry_count), 1);

    // Reset in the middle of a held press
    do_reset();
    press(4'h3, 10);
    sw = 4'h7;
    tick(3);
    n0 = n_enter_seen;
    enter_raw = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("midrst_x", 32'(io8.x_out), 0);
    chk("midrst_count", 32'(io8.entry_count), 0);
    tick(1);
    reset = 1'b1;
    rel_cyc = cyc;
    tick(15);
    enter_raw = 1'b0;
    tick(8);
    chk("midrst_pulses", 32'(n_enter_seen - n0), 1);
    chk("midrst_latency", 32'(last_enter_cyc - rel_cyc), DEB + 3);
    chk("midrst_x_after", 32'(io8.x_out), 7);

    // Narrow counter wraps
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press(4'($urandom_range(0, 15)), 8);
      chk("wrap_count", 32'(io2.entry_count), 32'((i + 1) % 4));
    end

    // Randomized segments on both buttons and the switches
    do_reset();
    for (int s = 0; s < 300; s++) begin
      enter_raw = 1'($urandom_range(0, 1));
      lock_raw  = 1'($urandom_range(0, 1));
      sw        = 4'($urandom_range(0, 15));
      tick($urandom_range(1, 8));
      if ($urandom_range(0, 60) == 0) do_reset();
    end
    enter_raw = 1'b0;
    lock_raw = 1'b0;
    tick(20);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/entry_input_conditioner.md
Name: entry_input_conditioner

Overview:
- Front-end stage that sits directly upstream of the combination-lock FSM.
- Takes raw board inputs: the asynchronous, bouncy enter and lock push-buttons and the 4-bit digit switches.
- Produces clean, clock-synchronous, single-cycle enter/lock strobes plus a registered digit value captured at the moment of the accepted press.
- The lock FSM consumes x_out/enter_pulse/lock_pulse directly as its x/enter/lock inputs.

Parameters:
- DEBOUNCE_CYCLES, default 4, consecutive synchronized cycles a button must hold a new level before the level is accepted; legal range 1..65535.
- COUNT_W, default 8, width of the entry_count status counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- btn_enter_raw  input  1  raw enter push-button, asynchronous, bouncy, active-high.
- btn_lock_raw  input  1  raw lock push-button, asynchronous, bouncy, active-high.
- sw_raw  input  4  raw digit switches, asynchronous.
- x_out  output  4  digit captured at the last accepted enter press; feeds the lock x input.
- enter_pulse  output  1  one-cycle strobe per accepted enter press.
- lock_pulse  output  1  one-cycle strobe per accepted lock press.
- enter_level  output  1  debounced enter level (status/LED).
- entry_count  output  COUNT_W  number of enter_pulse strobes issued, wrapping.

Behaviour:
- Reset (reset==0 at a clk edge): every register clears to 0 on that edge.
  - This covers the sync flops, debounced levels, debounce counters and edge registers.
  - Outputs after reset: x_out=0, enter_pulse=0, lock_pulse=0, enter_level=0, entry_count=0.
- Synchronizer: btn_enter_raw, btn_lock_raw and sw_raw[3:0] each pass through a 2-flop synchronizer. Only the second-stage values (enter_s, lock_s, sw_s) are used downstream.
- Debounce, per button (enter, lock), each with its own stable level and a counter of width clog2(DEBOUNCE_CYCLES+1):
  - If synced == stable, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter would reach DEBOUNCE_CYCLES, stable takes the synced value and the counter clears.
  - Any glitch back to the stable level before that point restarts the count from 0.
- Edge detect:
  - An accepted press is a registered 0->1 transition of a stable level. Release (1->0) produces no strobe.
  - Each strobe is exactly one cycle wide.
  - A held button produces exactly one strobe, and no further strobe until it is released and pressed again.
- Latency: with the raw input held clean from before edge 1, the strobe is high in the cycle after edge DEBOUNCE_CYCLES+3. For the default that is edge 7.
- Digit capture:
  - On the edge that raises enter_pulse, x_out loads sw_s. x_out therefore changes in the same cycle enter_pulse goes high.
  - x_out holds its value otherwise, including across switch changes.
- Simultaneous events: if enter and lock presses are accepted on the same edge, lock wins.
  - lock_pulse=1, enter_pulse=0.
  - x_out and entry_count are unchanged.
  - The enter press is consumed and not re-issued later.
- entry_count increments by 1 on each enter_pulse and wraps from 2^COUNT_W-1 to 0.
- Reset mid-operation:
  - Any in-progress debounce count is discarded, and no strobe is issued on the reset edge.
  - A button still held when reset releases is debounced afresh from stable=0, so it yields one strobe after the full latency.
- enter_level equals the enter stable level. It is registered, so it is glitch-free.

Test Plan:
- Clean press: DEBOUNCE_CYCLES=4, sw_raw=4'h2, raise btn_enter_raw and hold 20 cycles -> enter_pulse high for exactly 1 cycle, 7 edges after the raise; x_out=2 in that cycle; entry_count=1; no second pulse while held.
- Bounce rejection: toggle btn_enter_raw with 1-3 cycle high periods for 30 cycles, then settle low -> no enter_pulse, entry_count=0, enter_level stays 0.
- Sequence 2,3,4,6: four clean presses with sw_raw set before each, changing sw_raw between presses -> x_out takes 2,3,4,6 exactly on the four pulse cycles; entry_count=4; x_out holds when sw_raw changes with no press.
- Simultaneous: raise btn_enter_raw and btn_lock_raw on the same cycle with sw_raw=9 -> lock_pulse=1 once, enter_pulse never asserts, x_out and entry_count unchanged.
- Reset mid-debounce: assert reset (0) at 3 cycles into a held press, release after 2 cycles, keep the button held -> all outputs 0 during reset; one enter_pulse 7 edges after reset release.
- Wrap: COUNT_W=2, issue 5 clean enter presses -> entry_count goes 1,2,3,0,1.
